// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven sequencer that latches operands/opcode, runs the ALU for one cycle, supports chaining
module calc_ctrl #(
    parameter int W    = 4,
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_valid,
    input  logic            digit_valid,
    input  logic [W-1:0]    digit,
    input  logic            op_valid,
    input  logic [OP_W-1:0] op_code,
    input  logic            eq_valid,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [W-1:0]    alu_result,
    output logic [W-1:0]    display,
    output logic            result_valid,
    output logic            busy,
    output logic            err
);
    localparam logic [1:0] S_A = 2'd0, S_B = 2'd1, S_EXEC = 2'd2, S_DONE = 2'd3;
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);
    logic [1:0]      state;
    logic [W-1:0]    reg_a, reg_b, result;
    logic [OP_W-1:0] op_reg;
    logic            b_loaded, legal, ev_op, ev_dig;
    // eq outranks op, op outranks digit; clr is handled ahead of all of them
    assign legal  = op_code <= OP_NOT;
    assign ev_op  = op_valid && !eq_valid;
    assign ev_dig = digit_valid && !op_valid && !eq_valid;
    assign alu_a  = reg_a;
    assign alu_b  = (op_reg == OP_NOT) ? '0 : reg_b;
    assign alu_op = op_reg;
    assign busy   = state == S_EXEC;
    always_comb begin
        display = (state == S_DONE) ? result :
                  (state == S_B && b_loaded) ? reg_b : reg_a;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_A;
            reg_a        <= '0;
            reg_b        <= '0;
            op_reg       <= '0;
            result       <= '0;
            b_loaded     <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err          <= 1'b0;
            if (clr_valid) begin
                state    <= S_A;
                reg_a    <= '0;
                reg_b    <= '0;
                op_reg   <= '0;
                result   <= '0;
                b_loaded <= 1'b0;
            end else begin
                case (state)
                    S_A, S_DONE: begin
                        if (ev_op && legal) begin
                            op_reg <= op_code;
                            if (state == S_DONE) reg_a <= result;
                            if (op_code == OP_NOT) state <= S_EXEC;
                            else begin
                                state    <= S_B;
                                reg_b    <= '0;
                                b_loaded <= 1'b0;
                            end
                        end else if (ev_op) err <= 1'b1;
                        else if (ev_dig) begin
                            reg_a <= digit;
                            state <= S_A;
                        end
                    end
                    S_B: begin
                        if (eq_valid) state <= b_loaded ? S_EXEC : S_B;
                        else if (ev_op && legal) begin
                            op_reg <= op_code;
                            if (op_code == OP_NOT) state <= S_EXEC;
                        end else if (ev_op) err <= 1'b1;
                        else if (ev_dig) begin
                            reg_b    <= digit;
                            b_loaded <= 1'b1;
                        end
                    end
                    default: begin
                        result       <= alu_result;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: table-driven calc_ctrl bench with a behavioural ALU and a result scoreboard
module tb_calc_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       clr_valid = 0, digit_valid = 0, op_valid = 0, eq_valid = 0;
    logic [3:0] digit = 0;
    logic [2:0] op_code = 0;
    logic [3:0] alu_a, alu_b, alu_result, display;
    logic [2:0] alu_op;
    logic       result_valid, busy, err;
    int         n_vec = 0, n_bad = 0;
    logic [3:0] sb[$];

    typedef struct {
        logic [3:0] a;
        logic [2:0] op;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[9];

    calc_ctrl #(.W(4), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .clr_valid(clr_valid), .digit_valid(digit_valid), .digit(digit),
        .op_valid(op_valid), .op_code(op_code), .eq_valid(eq_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .display(display), .result_valid(result_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            3'd5:    alu_result = ~alu_a;
            default: alu_result = 4'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic c, input logic d, input logic o, input logic e,
                         input logic [3:0] dv, input logic [2:0] ov);
        @(negedge clk);
        clr_valid = c; digit_valid = d; op_valid = o; eq_valid = e; digit = dv; op_code = ov;
        @(negedge clk);
        clr_valid = 0; digit_valid = 0; op_valid = 0; eq_valid = 0;
    endtask

    task automatic wait_result(input string name);
        logic [3:0] e;
        int k = 0;
        while (!result_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, result_valid, 1);
        if (sb.size() == 0) check({name, "_sb_empty"}, 1, 0);
        else begin
            e = sb.pop_front();
            check({name, "_display"}, display, e);
        end
        check({name, "_busy_done"}, busy, 0);
        @(negedge clk);
        check({name, "_valid_pulse"}, result_valid, 0);
    endtask

    initial begin
        tbl[0] = '{4'd5,  3'd0, 4'd3,  4'd8};
        tbl[1] = '{4'd7,  3'd1, 4'd2,  4'd5};
        tbl[2] = '{4'd2,  3'd1, 4'd7,  4'd11};
        tbl[3] = '{4'd5,  3'd2, 4'd12, 4'd4};
        tbl[4] = '{4'd9,  3'd3, 4'd5,  4'd13};
        tbl[5] = '{4'd15, 3'd0, 4'd1,  4'd0};
        tbl[6] = '{4'd6,  3'd4, 4'd3,  4'd5};
        tbl[7] = '{4'd2,  3'd5, 4'd9,  4'd13};
        tbl[8] = '{4'd0,  3'd5, 4'd0,  4'd15};

        repeat (2) @(negedge clk);
        check("rst_display", display, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_err", err, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst_alu_a", alu_a, 0);

        foreach (tbl[i]) begin
            pulse(1, 0, 0, 0, 0, 0);
            pulse(0, 1, 0, 0, tbl[i].a, 0);
            check("vec_display_a", display, tbl[i].a);
            if (tbl[i].op == 3'd5) begin
                sb.push_back(tbl[i].exp);
                pulse(0, 0, 1, 0, 0, tbl[i].op);
            end else begin
                pulse(0, 0, 1, 0, 0, tbl[i].op);
                pulse(0, 1, 0, 0, tbl[i].b, 0);
                check("vec_display_b", display, tbl[i].b);
                sb.push_back(tbl[i].exp);
                pulse(0, 0, 0, 1, 0, 0);
            end
            check("vec_busy", busy, 1);
            check("vec_alu_a", alu_a, tbl[i].a);
            check("vec_alu_b", alu_b, (tbl[i].op == 3'd5) ? 4'd0 : tbl[i].b);
            check("vec_alu_op", alu_op, tbl[i].op);
            wait_result("vec");
        end

        // chain 7-2=5, then &12 = 4, then a fresh digit starts over
        pulse(1, 0, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 7, 0);
        pulse(0, 0, 1, 0, 0, 1);
        pulse(0, 1, 0, 0, 2, 0);
        sb.push_back(4'd5);
        pulse(0, 0, 0, 1, 0, 0);
        wait_result("chain1");
        pulse(0, 0, 1, 0, 0, 2);
        check("chain_display_a", display, 5);
        pulse(0, 1, 0, 0, 12, 0);
        check("chain_display_b", display, 12);
        sb.push_back(4'd4);
        pulse(0, 0, 0, 1, 0, 0);
        check("chain_alu_a", alu_a, 5);
        check("chain_alu_b", alu_b, 12);
        wait_result("chain2");
        pulse(0, 1, 0, 0, 9, 0);
        check("chain_new_digit", display, 9);
        pulse(0, 0, 0, 1, 0, 0);
        check("eq_in_a_busy", busy, 0);

        // unary not, then an illegal opcode in S_DONE
        pulse(1, 0, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 2, 0);
        sb.push_back(4'd13);
        pulse(0, 0, 1, 0, 0, 5);
        check("not_alu_b", alu_b, 0);
        wait_result("not");
        pulse(0, 0, 1, 0, 0, 6);
        check("illegal_err", err, 1);
        check("illegal_display", display, 13);
        @(negedge clk);
        check("illegal_err_pulse", err, 0);
        pulse(0, 0, 1, 0, 0, 7);
        check("illegal7_err", err, 1);
        check("illegal7_busy", busy, 0);

        // eq before any B digit is ignored
        pulse(1, 0, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 9, 0);
        pulse(0, 0, 1, 0, 0, 3);
        pulse(0, 0, 0, 1, 0, 0);
        check("early_eq_busy", busy, 0);
        check("early_eq_display", display, 9);
        check("legal_no_err", err, 0);
        pulse(0, 1, 0, 0, 5, 0);
        sb.push_back(4'd13);
        pulse(0, 0, 0, 1, 0, 0);
        wait_result("late_eq");

        // clr + digit + eq in one cycle: clear wins
        pulse(0, 1, 0, 0, 3, 0);
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 4, 0);
        check("pre_clr_display", display, 4);
        pulse(1, 1, 0, 1, 7, 0);
        check("clr_display", display, 0);
        check("clr_busy", busy, 0);
        check("clr_alu_a", alu_a, 3'd0);

        // async reset during execute discards the result
        pulse(0, 1, 0, 0, 5, 0);
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 3, 0);
        pulse(0, 0, 0, 1, 0, 0);
        check("rst_exec_busy", busy, 1);
        rst = 1;
        #1;
        check("rst_exec_display", display, 0);
        check("rst_exec_busy0", busy, 0);
        check("rst_exec_alu_b", alu_b, 0);
        @(negedge clk);
        rst = 0;
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (result_valid) seen++;
            end
            check("rst_exec_no_valid", seen, 0);
        end

        // clr during execute also suppresses result_valid
        pulse(0, 1, 0, 0, 5, 0);
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 3, 0);
        pulse(0, 0, 0, 1, 0, 0);
        check("clr_exec_busy", busy, 1);
        clr_valid = 1;
        @(negedge clk);
        clr_valid = 0;
        check("clr_exec_no_valid", result_valid, 0);
        check("clr_exec_display", display, 0);
        check("clr_exec_busy0", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
